vctr_frame_seq: RTL and testbench
=================================

# vctr_frame_seq

Frame sequencer between the UART byte receiver and the vector input/output load buffers. It parses the received byte stream into framed vector-load commands: header, length, payload, checksum. Payload bytes are steered as addressed writes to the input-vector or output-vector buffer, and each frame ends with exactly one completion or error pulse. It replaces ad-hoc completion wiring between the receiver and the vector block with one explicit state machine.

## Interface
Parameters:
- DEPTH, 16: max payload bytes per frame (1..255); address width AW = clog2(DEPTH), min 1
- HDR_IN, 8'hA5: header byte selecting the input-vector channel
- HDR_OUT, 8'h5A: header byte selecting the output-vector channel
- TIMEOUT, 10000: idle clock cycles tolerated between bytes inside a frame

Ports:
- clock  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- vin_we  out  1  write strobe, input-vector buffer
- vout_we  out  1  write strobe, output-vector buffer
- vec_addr  out  AW  write address (shared by both channels)
- vec_data  out  8  write data (shared)
- comp_in  out  1  one-cycle pulse: input-vector frame accepted
- comp_out  out  1  one-cycle pulse: output-vector frame accepted
- err  out  1  one-cycle pulse: frame aborted
- err_code  out  2  0 none, 1 bad length, 2 bad checksum, 3 timeout; held until next accepted header
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM.
- IDLE: on rx_valid, HDR_IN -> LEN with sel=0; HDR_OUT -> LEN with sel=1. Any other byte is ignored, with no error. Accepting a header clears err_code.
- LEN: on rx_valid, latch len = rx_byte, clear cnt and csum.
  - len==0 or len>DEPTH: err pulse, err_code=1, go to IDLE.
  - Otherwise go to PAYLOAD.
- PAYLOAD: on each rx_valid:
  - vec_data=rx_byte, vec_addr=cnt[AW-1:0].
  - Pulse vin_we if sel=0, else vout_we.
  - csum = csum + rx_byte, mod 256 (8-bit wrap).
  - cnt++.
  - On the byte where cnt==len-1: go to CSUM.
- CSUM: on rx_valid:
  - rx_byte==csum: pulse comp_in (sel=0) or comp_out (sel=1).
  - Otherwise: err pulse, err_code=2.
  - Either way, go to IDLE.
- Buffer writes are not rolled back on error. The consumer treats buffer contents as valid only after the comp pulse.
- Timeout: a cycle counter runs in every non-IDLE state and is cleared on rx_valid and on entry to IDLE. When it reaches TIMEOUT: err pulse, err_code=3, go to IDLE.
- rx_valid and timeout terminal count in the same cycle: rx_valid wins; the byte is processed and the counter is cleared.
- comp_in, comp_out and err are mutually exclusive. At most one of them pulses per frame.

## Timing
- All outputs are registered.
- Reset values: vin_we, vout_we, comp_in, comp_out, err, busy = 0; vec_addr, vec_data = 0; err_code = 0; state = IDLE; counters = 0.
- Write latency: the rx_valid at edge N produces vin_we or vout_we high for exactly the cycle after edge N, with vec_addr/vec_data valid in that same cycle.
- vec_addr/vec_data hold their values between writes.
- The comp or err pulse is high for one cycle, starting one cycle after the terminating rx_valid or timeout.
- busy rises the cycle after the header byte strobe. It falls in the same cycle the comp/err pulse is high.
- Back-to-back rx_valid on consecutive cycles is supported with no lost bytes.
- A header byte arriving the cycle after a terminating byte is accepted.
- nrst asserted mid-frame: immediate return to IDLE and all outputs to reset values. No comp or err pulse is issued for the aborted frame.

## Test plan
- Frame A5,03,11,22,33,66 -> vin_we pulses at addr 0,1,2 with data 11,22,33; one comp_in pulse; err never asserted; busy low after.
- Frame 5A,02,F0,20,10 (csum wraps: F0+20=10) -> vout_we at addr 0,1; one comp_out pulse.
- Frame A5,03,01,02,03,07 -> 3 writes, then err pulse with err_code=2; no comp.
- Length errors: A5,00 -> err, err_code=1; A5,11 (17 > DEPTH) -> err, err_code=1; neither produces any writes. Stray bytes 00,FF in IDLE -> no outputs.
- A5,02,AA then silence -> err with err_code=3 exactly TIMEOUT cycles after the AA strobe. Variant: a byte arriving on the terminal-count cycle is processed, with no error.
- nrst pulsed after 2 payload bytes -> outputs at reset values and busy=0. The next full valid frame completes normally with comp_in.

Source files
------------

// File: rtl/vctr_frame_seq.sv
// Frame sequencer: parses header/length/payload/checksum byte frames from the UART
// receiver into addressed vector-buffer writes, ending each frame with one comp or err pulse.
module vctr_frame_seq #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [7:0]  HDR_IN  = 8'hA5,
   parameter logic [7:0]  HDR_OUT = 8'h5A,
   parameter int unsigned TIMEOUT = 10000,
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clock,
   input  logic          nrst,
   input  logic          rx_valid,
   input  logic [7:0]    rx_byte,
   output logic          vin_we,
   output logic          vout_we,
   output logic [AW-1:0] vec_addr,
   output logic [7:0]    vec_data,
   output logic          comp_in,
   output logic          comp_out,
   output logic          err,
   output logic [1:0]    err_code,
   output logic          busy
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;

   state_t        state, state_nxt;
   logic          sel, sel_nxt;
   logic [7:0]    len, len_nxt;
   logic [7:0]    cnt, cnt_nxt;
   logic [7:0]    csum, csum_nxt;
   logic [TW-1:0] tmo, tmo_nxt;
   logic          vin_we_nxt, vout_we_nxt;
   logic [AW-1:0] addr_nxt;
   logic [7:0]    data_nxt;
   logic          comp_in_nxt, comp_out_nxt, err_nxt, busy_nxt;
   logic [1:0]    err_code_nxt;

   // State and registered outputs
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         sel      <= 1'b0;
         len      <= '0;
         cnt      <= '0;
         csum     <= '0;
         tmo      <= '0;
         vin_we   <= 1'b0;
         vout_we  <= 1'b0;
         vec_addr <= '0;
         vec_data <= '0;
         comp_in  <= 1'b0;
         comp_out <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         len      <= len_nxt;
         cnt      <= cnt_nxt;
         csum     <= csum_nxt;
         tmo      <= tmo_nxt;
         vin_we   <= vin_we_nxt;
         vout_we  <= vout_we_nxt;
         vec_addr <= addr_nxt;
         vec_data <= data_nxt;
         comp_in  <= comp_in_nxt;
         comp_out <= comp_out_nxt;
         err      <= err_nxt;
         err_code <= err_code_nxt;
         busy     <= busy_nxt;
      end
   end

   // Next state; a received byte takes priority over an expiring timeout
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      len_nxt      = len;
      cnt_nxt      = cnt;
      csum_nxt     = csum;
      tmo_nxt      = '0;
      vin_we_nxt   = 1'b0;
      vout_we_nxt  = 1'b0;
      addr_nxt     = vec_addr;
      data_nxt     = vec_data;
      comp_in_nxt  = 1'b0;
      comp_out_nxt = 1'b0;
      err_nxt      = 1'b0;
      err_code_nxt = err_code;

      if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_byte == HDR_IN) begin
                  state_nxt    = LEN;
                  sel_nxt      = 1'b0;
                  err_code_nxt = 2'd0;
               end else if (rx_byte == HDR_OUT) begin
                  state_nxt    = LEN;
                  sel_nxt      = 1'b1;
                  err_code_nxt = 2'd0;
               end
            end
            LEN: begin
               len_nxt  = rx_byte;
               cnt_nxt  = 8'd0;
               csum_nxt = 8'd0;
               if (rx_byte == 8'd0 || rx_byte > 8'(DEPTH)) begin
                  err_nxt      = 1'b1;
                  err_code_nxt = 2'd1;
                  state_nxt    = IDLE;
               end else begin
                  state_nxt = PAYLOAD;
               end
            end
            PAYLOAD: begin
               data_nxt    = rx_byte;
               addr_nxt    = cnt[AW-1:0];
               vin_we_nxt  = !sel;
               vout_we_nxt = sel;
               csum_nxt    = csum + rx_byte;
               cnt_nxt     = cnt + 8'd1;
               if (cnt == len - 8'd1) state_nxt = CSUM;
            end
            CSUM: begin
               if (rx_byte == csum) begin
                  comp_in_nxt  = !sel;
                  comp_out_nxt = sel;
               end else begin
                  err_nxt      = 1'b1;
                  err_code_nxt = 2'd2;
               end
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state != IDLE) begin
         if (tmo == TW'(TIMEOUT - 1)) begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'd3;
            state_nxt    = IDLE;
         end else begin
            tmo_nxt = tmo + TW'(1);
         end
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_vctr_frame_seq.sv
// Scoreboard bench for vctr_frame_seq: directed frames push expected writes/pulses
// with their cycle; a negedge monitor pops and compares every strobe the DUT shows.
module tb_vctr_frame_seq;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 40;
   localparam int unsigned AW      = 4;

   logic          clock;
   logic          nrst;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic          vin_we, vout_we, comp_in, comp_out, err, busy;
   logic [AW-1:0] vec_addr;
   logic [7:0]    vec_data;
   logic [1:0]    err_code;

   typedef struct {
      int kind;   // 0 vin write, 1 vout write, 2 comp_in, 3 comp_out, 4 err
      int addr;
      int data;
      int code;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   vctr_frame_seq #(
      .DEPTH(DEPTH), .HDR_IN(8'hA5), .HDR_OUT(8'h5A), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .nrst(nrst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .vin_we(vin_we), .vout_we(vout_we), .vec_addr(vec_addr), .vec_data(vec_data),
      .comp_in(comp_in), .comp_out(comp_out), .err(err), .err_code(err_code),
      .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   function automatic void ew(input int ch, input int a, input int d, input int c);
      exp_t e;
      e.kind = ch; e.addr = a; e.data = d; e.code = 0; e.cyc = c;
      q.push_back(e);
   endfunction

   function automatic void ev(input int k, input int code, input int c);
      exp_t e;
      e.kind = k; e.addr = 0; e.data = 0; e.code = code; e.cyc = c;
      q.push_back(e);
   endfunction

   // Drive one byte strobe; c returns the cycle index of the sampling edge
   task automatic tx(input logic [7:0] b, output int c);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
      c        = cyc;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: every strobe must match the head of the expected queue
   always @(negedge clock) begin : mon
      int   ns;
      int   kind;
      exp_t e;
      ns = int'(vin_we) + int'(vout_we) + int'(comp_in) + int'(comp_out) + int'(err);
      if (ns != 0) begin
         kind = vin_we ? 0 : vout_we ? 1 : comp_in ? 2 : comp_out ? 3 : 4;
         chk("strobe_exclusive", ns, 1);
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got kind %0d expected none at cyc %0d", kind, cyc);
         end else begin
            e = q.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_cycle", cyc, e.cyc);
            if (kind < 2) begin
               chk("wr_addr", int'(vec_addr), e.addr);
               chk("wr_data", int'(vec_data), e.data);
            end else if (kind == 4) begin
               chk("err_code", int'(err_code), e.code);
            end
         end
      end
   end

   initial begin
      int c;
      int c_aa;
      nrst     = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_vec_addr", int'(vec_addr), 0);
      chk("rst_vec_data", int'(vec_data), 0);
      nrst = 1'b1;
      idle(1);

      // Input frame, followed back-to-back by an output frame whose checksum wraps
      tx(8'hA5, c);
      chk("busy_after_hdr", int'(busy), 1);
      tx(8'h03, c);
      tx(8'h11, c); ew(0, 0, 'h11, c);
      tx(8'h22, c); ew(0, 1, 'h22, c);
      tx(8'h33, c); ew(0, 2, 'h33, c);
      tx(8'h66, c); ev(2, 0, c);
      chk("busy_after_comp", int'(busy), 0);
      tx(8'h5A, c);
      tx(8'h02, c);
      tx(8'hF0, c); ew(1, 0, 'hF0, c);
      tx(8'h20, c); ew(1, 1, 'h20, c);
      tx(8'h10, c); ev(3, 0, c);
      idle(2);
      chk("hold_vec_addr", int'(vec_addr), 1);
      chk("hold_vec_data", int'(vec_data), 'h20);

      // Bad checksum: writes remain, err code 2 held in idle
      tx(8'hA5, c);
      tx(8'h03, c);
      tx(8'h01, c); ew(0, 0, 'h01, c);
      tx(8'h02, c); ew(0, 1, 'h02, c);
      tx(8'h03, c); ew(0, 2, 'h03, c);
      tx(8'h07, c); ev(4, 2, c);
      idle(3);
      chk("err_code_held", int'(err_code), 2);
      chk("busy_after_err", int'(busy), 0);

      // Length errors
      tx(8'hA5, c);
      chk("err_code_cleared_by_hdr", int'(err_code), 0);
      tx(8'h00, c); ev(4, 1, c);
      tx(8'hA5, c);
      tx(8'h11, c); ev(4, 1, c);
      idle(2);
      chk("err_code_len", int'(err_code), 1);

      // Stray bytes in IDLE do nothing
      tx(8'h00, c);
      tx(8'hFF, c);
      idle(2);
      chk("busy_stray", int'(busy), 0);
      chk("err_code_stray", int'(err_code), 1);

      // Timeout exactly TIMEOUT cycles after the last byte
      tx(8'hA5, c);
      tx(8'h02, c);
      tx(8'hAA, c_aa); ew(0, 0, 'hAA, c_aa);
      ev(4, 3, c_aa + TIMEOUT);
      idle(TIMEOUT + 4);
      chk("err_code_timeout", int'(err_code), 3);
      chk("busy_timeout", int'(busy), 0);

      // Byte on the terminal-count cycle wins over the timeout
      tx(8'hA5, c);
      tx(8'h02, c);
      tx(8'hAA, c_aa); ew(0, 0, 'hAA, c_aa);
      repeat (TIMEOUT - 1) @(posedge clock);
      #1;
      tx(8'hBB, c); ew(0, 1, 'hBB, c_aa + TIMEOUT);
      tx(8'h65, c); ev(2, 0, c);
      idle(2);
      chk("err_code_tc_ok", int'(err_code), 0);

      // Reset mid-frame, then a complete frame
      tx(8'hA5, c);
      tx(8'h03, c);
      tx(8'h01, c); ew(0, 0, 'h01, c);
      tx(8'h02, c); ew(0, 1, 'h02, c);
      @(negedge clock);
      #1;
      nrst = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_vec_addr", int'(vec_addr), 0);
      chk("midrst_vec_data", int'(vec_data), 0);
      chk("midrst_strobes", int'({vin_we, vout_we, comp_in, comp_out, err}), 0);
      @(posedge clock);
      #1;
      nrst = 1'b1;
      idle(1);
      tx(8'hA5, c);
      tx(8'h03, c);
      tx(8'h11, c); ew(0, 0, 'h11, c);
      tx(8'h22, c); ew(0, 1, 'h22, c);
      tx(8'h33, c); ew(0, 2, 'h33, c);
      tx(8'h66, c); ev(2, 0, c);
      idle(3);
      chk("busy_final", int'(busy), 0);
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
